csel_sub_pipe_64: RTL and testbench
===================================

// Module: csel_sub_pipe_64
// PURPOSE
//  - Pipelined 64-bit unsigned/two's-complement subtractor: diff = a - b - bin.
//  - Built from BLK-bit carry-select slices, one slice per pipeline stage.
//  - The borrow ripples stage-to-stage through registers.
//  - Inverse companion of the carry-select adder datapath; used wherever the ALU needs a difference.
//  - valid/ready on both sides; throughput 1 op/cycle; fixed latency STAGES cycles.
// PARAMETERS
//  WIDTH   64          operand width; must equal BLK*STAGES
//  BLK     16          slice width (bits per pipeline stage)
//  STAGES  WIDTH/BLK   derived (localparam), = 4 at defaults
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat when in_valid & in_ready
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts when out_valid & out_ready
//  diff       out  WIDTH  a - b - bin, mod 2^WIDTH
//  bout       out  1      borrow out: 1 iff a < b + bin (unsigned)
//  ovf        out  1      signed overflow: (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB])
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
//  - Reset: every stage valid bit is 0, every data/borrow register is 0.
//    After reset, out_valid=0, diff=0, bout=0, ovf=0 and in_ready=1.
//  - Arithmetic per slice k: computes a_k + ~b_k + c_in, where c_in = ~borrow_in.
//    Both carry-in candidates (0 and 1) are computed in parallel; the registered borrow selects one.
//    Slice borrow_out = ~carry_out. Stage 0 uses borrow_in = bin.
//  - Pipeline:
//    - Stage k registers diff slice k and its borrow.
//    - Unconsumed upper a/b slices travel forward in skew registers.
//    - Completed lower diff slices also travel forward.
//    - The final stage register drives diff, bout and ovf directly. Outputs are registered, with no comb path from inputs.
//    - ovf is computed from the a[MSB] and b[MSB] carried to the last stage.
//  - Latency: a beat accepted on edge N appears with out_valid=1 after edge N+STAGES-1.
//    At defaults, that is 4 register stages.
//  - Flow control, with a single global enable en = ~out_valid | out_ready:
//    - in_ready = en (combinational from out_valid and out_ready only).
//    - When en=0, every stage holds its data and valid bits. diff/bout/ovf are stable while out_valid & ~out_ready.
//    - When en=1, all stages advance. Stage 0 valid loads in_valid.
//    - Bubbles are not compressed; a held bubble stalls upstream. This is accepted for simplicity.
//  - Ordering: results leave in acceptance order, with none dropped or duplicated.
//  - Boundaries:
//    - A full-width borrow ripple (0 - 1) is handled without extra latency.
//    - bin=1 with a=b gives diff=all-ones and bout=1.
//    - Simultaneous accept and output on the same edge is legal and sustains full throughput.
//    - in_valid=0 inserts a bubble: stage valid bit is 0 and data is don't-care, but held at the last value.
//  - Reset mid-operation: all in-flight beats are discarded with no output. The next cycle shows the reset values above.
//  - Datapath registers are updated only when en=1. Valid bits clear only on rst or when a bubble advances.
// STRUCTURE
//  - Sub-module csel_sub_block: combinational BLK-bit carry-select subtract slice.
//    Ports: a, b, bin, diff, bout. Contains two ripple chains (carry-in 0 and 1) and an output mux.
//    Instantiated STAGES times via generate.
//  - Shared definitions header: CSEL_WIDTH=64 and CSEL_BLK=16, shared with the adder top-levels.
//    No typedefs are needed.
//  - The top holds the stage registers, skew registers, the enable and the ovf logic.
// TESTING
//  - Basic case: rst for 2 cycles, then a=5, b=3, bin=0 with out_ready=1.
//    Expect out_valid exactly 4 cycles later with diff=2, bout=0, ovf=0.
//  - Full borrow ripple: a=0, b=1, bin=0 -> diff=64'hFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
//  - Cross-slice borrow: a=64'h0000_0001_0000_0000, b=0, bin=1 -> diff=64'h0000_0000_FFFF_FFFF, bout=0.
//  - Signed overflow: a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
//  - Backpressure: 16 random beats back-to-back with out_ready toggled pseudo-randomly.
//    Compare against a golden model (a-b-bin): same order, no loss or duplication, outputs stable while stalled.
//  - Reset in flight: assert rst with 3 beats in flight.
//    Next cycle: out_valid=0, diff=0, in_ready=1; none of the 3 beats ever emerges.

Source files
------------

// File: rtl/csel_sub_pipe_64_pkg.sv
// Shared carry-select datapath sizing, common to the adder and subtractor tops.
package csel_sub_pipe_64_pkg;

    localparam int CSEL_WIDTH = 64;  // full operand width
    localparam int CSEL_BLK   = 16;  // bits handled per carry-select slice / stage

endpackage : csel_sub_pipe_64_pkg

// File: rtl/csel_sub_block.sv
// Combinational BLK-bit carry-select subtract slice: diff = a - b - bin.
// Two ripple chains compute a + ~b + cin for cin=0 and cin=1 in parallel;
// the incoming borrow selects between them (cin = ~bin).
module csel_sub_block
    import csel_sub_pipe_64_pkg::*;
#(
    parameter int BLK = CSEL_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           bin,
    output logic [BLK-1:0] diff,
    output logic           bout
);

    logic [BLK-1:0] sum_c0;
    logic [BLK-1:0] sum_c1;
    logic           cout_c0;
    logic           cout_c1;

    // Both speculative ripple chains over a + ~b.
    always_comb begin
        logic k0;
        logic k1;
        logic nb;
        // NOTE: every output of a comb block gets a default first, so no path leaves it unassigned (no latch).
        sum_c0 = '0;
        sum_c1 = '0;
        k0     = 1'b0;
        k1     = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            nb        = ~b[i];
            sum_c0[i] = a[i] ^ nb ^ k0;
            sum_c1[i] = a[i] ^ nb ^ k1;
            k0        = (a[i] & nb) | (k0 & (a[i] ^ nb));
            k1        = (a[i] & nb) | (k1 & (a[i] ^ nb));
        end
        cout_c0 = k0;
        cout_c1 = k1;
    end

    // Borrow-in 1 means carry-in 0; a slice borrows out when it does not carry out.
    always_comb begin
        diff = bin ? sum_c0 : sum_c1;
        bout = bin ? ~cout_c0 : ~cout_c1;
    end

endmodule : csel_sub_block

// File: rtl/csel_sub_pipe_64.sv
// Pipelined carry-select subtractor: diff = a - b - bin, one BLK-bit slice per stage.
// The borrow ripples stage to stage through registers. Pending a/b slices move
// forward in right-shifting skew registers, so the next slice to consume always
// sits at bits [BLK-1:0]; finished diff slices are shifted in from the top, so the
// last stage holds the complete difference in natural bit order.
// Requires WIDTH == BLK*STAGES and STAGES >= 2.
module csel_sub_pipe_64
    import csel_sub_pipe_64_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int BLK   = CSEL_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLK;
    localparam int SKW    = WIDTH - BLK;

    // Stage registers
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] brw_q,   brw_d;
    logic [WIDTH-1:0]  dacc_q  [STAGES];
    logic [WIDTH-1:0]  dacc_d  [STAGES];
    logic [SKW-1:0]    askew_q [STAGES-1];
    logic [SKW-1:0]    askew_d [STAGES-1];
    logic [SKW-1:0]    bskew_q [STAGES-1];
    logic [SKW-1:0]    bskew_d [STAGES-1];
    logic              ovf_q,   ovf_d;

    // Slice wiring and control
    logic [BLK-1:0]    sl_a    [STAGES];
    logic [BLK-1:0]    sl_b    [STAGES];
    logic [BLK-1:0]    sl_diff [STAGES];
    logic [STAGES-1:0] sl_bin;
    logic [STAGES-1:0] sl_bout;
    logic [STAGES-1:0] ld;
    logic              en;
    logic              a_msb;
    logic              b_msb;

    // Global enable: the whole pipe advances unless the result is held.
    always_comb begin
        en       = ~valid_q[STAGES-1] | out_ready;
        in_ready = en;
    end

    // Route each slice's operands: stage 0 from the ports, later stages from the skew registers.
    always_comb begin
        sl_a[0]   = a[BLK-1:0];
        sl_b[0]   = b[BLK-1:0];
        sl_bin[0] = bin;
        for (int k = 1; k < STAGES; k++) begin
            sl_a[k]   = askew_q[k-1][BLK-1:0];
            sl_b[k]   = bskew_q[k-1][BLK-1:0];
            sl_bin[k] = brw_q[k-1];
        end
        a_msb = askew_q[STAGES-2][BLK-1];
        b_msb = bskew_q[STAGES-2][BLK-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        csel_sub_block #(
            .BLK (BLK)
        ) u_blk (
            .a    (sl_a[k]),
            .b    (sl_b[k]),
            .bin  (sl_bin[k]),
            .diff (sl_diff[k]),
            .bout (sl_bout[k])
        );
    end

    // Next state: valid bits shift on every enabled edge; data loads only behind a valid beat, so bubbles hold the last data.
    always_comb begin
        valid_d = valid_q;
        brw_d   = brw_q;
        dacc_d  = dacc_q;
        askew_d = askew_q;
        bskew_d = bskew_q;
        ovf_d   = ovf_q;

        ld[0] = en & in_valid;
        for (int k = 1; k < STAGES; k++) begin
            ld[k] = en & valid_q[k-1];
        end

        if (en) begin
            valid_d = {valid_q[STAGES-2:0], in_valid};
        end

        for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
                brw_d[k] = sl_bout[k];
            end
        end

        if (ld[0]) begin
            dacc_d[0]  = {sl_diff[0], {SKW{1'b0}}};
            askew_d[0] = a[WIDTH-1:BLK];
            bskew_d[0] = b[WIDTH-1:BLK];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                dacc_d[k] = {sl_diff[k], dacc_q[k-1][WIDTH-1:BLK]};
            end
        end
        for (int k = 1; k < STAGES - 1; k++) begin
            if (ld[k]) begin
                askew_d[k] = askew_q[k-1] >> BLK;
                bskew_d[k] = bskew_q[k-1] >> BLK;
            end
        end

        // Signed overflow uses the operand MSBs carried alongside the top slice.
        if (ld[STAGES-1]) begin
            ovf_d = (a_msb ^ b_msb) & (sl_diff[STAGES-1][BLK-1] ^ a_msb);
        end
    end

    // State register with synchronous reset that discards every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, because diff/bout/ovf must read 0 straight after reset.
            valid_q <= '0;
            brw_q   <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                dacc_q[k] <= '0;
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                askew_q[k] <= '0;
                bskew_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
            valid_q <= valid_d;
            brw_q   <= brw_d;
            ovf_q   <= ovf_d;
            dacc_q  <= dacc_d;
            askew_q <= askew_d;
            bskew_q <= bskew_d;
        end
    end

    // Outputs come straight from the last stage registers.
    always_comb begin
        out_valid = valid_q[STAGES-1];
        diff      = dacc_q[STAGES-1];
        bout      = brw_q[STAGES-1];
        ovf       = ovf_q;
    end

endmodule : csel_sub_pipe_64

// File: tb/tb_csel_sub_pipe_64.sv
// Self-checking bench for csel_sub_pipe_64: directed corner cases with literal
// expectations, randomized back-pressure traffic against a queue-based golden
// model, and a reset with beats in flight.
module tb_csel_sub_pipe_64;

    localparam int W      = 64;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t         exp_q[$];
    logic         hold_pending = 1'b0;
    logic [W-1:0] held_diff    = '0;
    logic         held_bout    = 1'b0;

    always #5 clk = ~clk;

    csel_sub_pipe_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Golden model: plain 65-bit arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        exp_t e;
        r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (x[W-1] ^ y[W-1]) & (r[W-1] ^ x[W-1]);
        return e;
    endfunction

    // Compare process: sampled on the falling edge, predicts the transfers of the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            check("in_ready_rule", {63'd0, in_ready}, {63'd0, ~out_valid | out_ready});
            if (hold_pending) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_diff", diff, held_diff);
                check("hold_bout", {63'd0, bout}, {63'd0, held_bout});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    check("model_diff", diff, e.d);
                    check("model_bout", {63'd0, bout}, {63'd0, e.bo});
                    check("model_ovf", {63'd0, ovf}, {63'd0, e.ov});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
            end
            hold_pending = out_valid & ~out_ready;
            held_diff    = diff;
            held_bout    = bout;
        end
    end

    // One beat into an idle pipe with out_ready high; pins latency and literal results.
    task automatic send_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                            input logic [W-1:0] ed, input logic eb, input logic eo, input string tag);
        int  cnt;
        logic seen;
        @(posedge clk); #1;
        out_ready = 1'b1;
        a         = xa;
        b         = xb;
        bin       = xc;
        in_valid  = 1'b1;
        check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
            seen = out_valid;
        end
        if (!seen) begin
            check({tag, "_timeout"}, {63'd0, seen}, 64'd1);
        end else begin
            // Accept edge N plus STAGES-1 further edges fills the four register stages.
            check({tag, "_latency"}, 64'(cnt), 64'(STAGES - 1));
            check({tag, "_diff"}, diff, ed);
            check({tag, "_bout"}, {63'd0, bout}, {63'd0, eb});
            check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        end
    endtask

    task automatic rand_beat();
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: begin a = r1; b = r2;                 end
            1: begin a = r1; b = r1;                 end
            2: begin a = '0; b = {48'd0, r2[15:0]};  end
            default: begin a = {1'b1, r1[62:0]}; b = {1'b0, r2[62:0]}; end
        endcase
        bin = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int guard;
        logic fire;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_diff", diff, 64'd0);
        check("rst_bout", {63'd0, bout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;

        send_one(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, "basic");
        send_one(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "ripple");
        send_one(64'h0000_0001_0000_0000, 64'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, "xslice");
        send_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "sovf");
        send_one(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "eq_bin");

        // 16 back-to-back beats with random back-pressure; a stalled beat is held unchanged.
        @(posedge clk); #1;
        sent  = 0;
        guard = 0;
        rand_beat();
        in_valid = 1'b1;
        while (sent < 16 && guard < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk); #1;
            guard++;
            if (fire) begin
                sent++;
                if (sent < 16) rand_beat();
            end
        end
        in_valid = 1'b0;
        check("bp_all_sent", 64'(sent), 64'd16);
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b1;

        // Reset with three beats in flight: none may ever emerge.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_diff", diff, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("flush_quiet", {63'd0, out_valid}, 64'd0);
        end

        // Post-reset sanity: the pipe still works after a flush.
        send_one(64'd100, 64'd58, 1'b1, 64'd41, 1'b0, 1'b0, "post_rst");

        repeat (2) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_csel_sub_pipe_64
